// File: rtl/icache_nway.sv
// icache_nway: N-way set-associative, read-only instruction cache.
// The tag compare is done in the LOOKUP cycle, so a hit returns data one
// cycle after accept. Lines are filled in ascending word order, with
// pseudo-LRU replacement and a one-set-per-cycle invalidate sweep.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cpu_valid, cpu_addr           fetch request and address
//   cpu_addr_ok                   request accepted this cycle
//   cpu_data_ok, cpu_rdata        instruction word return
//   inv_req, inv_done             invalidate-all request / completion pulse
//   rd_req, rd_addr, rd_rdy       line-fill read request handshake
//   ret_valid, ret_last, ret_data fill beats
module icache_nway #(
  parameter int unsigned WAYS       = 2,
  parameter int unsigned SETS       = 256,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_valid,
  input  logic [31:0] cpu_addr,
  output logic        cpu_addr_ok,
  output logic        cpu_data_ok,
  output logic [31:0] cpu_rdata,
  input  logic        inv_req,
  output logic        inv_done,
  output logic        rd_req,
  output logic [31:0] rd_addr,
  input  logic        rd_rdy,
  input  logic        ret_valid,
  input  logic        ret_last,
  input  logic [31:0] ret_data
);

  localparam int unsigned WORD_W = $clog2(LINE_WORDS);
  localparam int unsigned OFF_W  = WORD_W + 2;
  localparam int unsigned IDX_W  = $clog2(SETS);
  localparam int unsigned TAG_W  = 32 - IDX_W - OFF_W;
  localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int unsigned PLRU_W = (WAYS > 1) ? WAYS - 1 : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOOKUP  = 3'd1;
  localparam logic [2:0] S_MISS    = 3'd2;
  localparam logic [2:0] S_REFILL  = 3'd3;
  localparam logic [2:0] S_RESPOND = 3'd4;
  localparam logic [2:0] S_INVAL   = 3'd5;

  logic [2:0]        state, state_nx;
  logic [31:0]       req_addr;
  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [WORD_W-1:0] req_word;

  logic [TAG_W-1:0]  tag_mem   [WAYS][SETS];
  logic [31:0]       data_mem  [WAYS][SETS][LINE_WORDS];
  logic [SETS-1:0]   valid_mem [WAYS];
  logic [PLRU_W-1:0] plru_mem  [SETS];

  logic [WORD_W-1:0] beat_cnt;
  logic [IDX_W-1:0]  inv_cnt;
  logic [31:0]       crit_word;

  logic              hit;
  logic [WAY_W-1:0]  hit_way;
  logic              has_inv;
  logic [WAY_W-1:0]  inv_way;
  logic [WAY_W-1:0]  plru_way;
  logic [WAY_W-1:0]  victim;
  logic [WAY_W-1:0]  use_way;
  logic [PLRU_W-1:0] plru_bits;
  logic [PLRU_W-1:0] plru_upd;

  assign req_tag   = req_addr[31 -: TAG_W];
  assign req_idx   = req_addr[OFF_W +: IDX_W];
  assign req_word  = req_addr[2 +: WORD_W];
  assign plru_bits = plru_mem[req_idx];

  // Parallel tag compare across all ways of the buffered set
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < int'(WAYS); w++) begin
      if (valid_mem[w][req_idx] && (tag_mem[w][req_idx] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Lowest-numbered invalid way; scanning downward lets the lowest win
  always_comb begin
    has_inv = 1'b0;
    inv_way = '0;
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (!valid_mem[w][req_idx]) begin
        has_inv = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
  end

  assign victim  = has_inv ? inv_way : plru_way;
  assign use_way = (state == S_LOOKUP) ? hit_way : victim;

  // PLRU tree: bit value names the side to replace next; update points away from use_way
  if (WAYS == 4) begin : g_plru4
    always_comb begin
      plru_way = plru_bits[0] ? {1'b1, plru_bits[2]} : {1'b0, plru_bits[1]};
      plru_upd = plru_bits;
      plru_upd[0] = ~use_way[1];
      if (use_way[1]) plru_upd[2] = ~use_way[0];
      else            plru_upd[1] = ~use_way[0];
    end
  end else if (WAYS == 2) begin : g_plru2
    always_comb begin
      plru_way = plru_bits[0];
      plru_upd = ~use_way[0];
    end
  end else begin : g_plru1
    always_comb begin
      plru_way = '0;
      plru_upd = plru_bits;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state and output decode
  always_comb begin
    state_nx    = state;
    cpu_addr_ok = 1'b0;
    cpu_data_ok = 1'b0;
    cpu_rdata   = data_mem[hit_way][req_idx][req_word];
    rd_req      = 1'b0;
    rd_addr     = {req_tag, req_idx, OFF_W'(0)};
    inv_done    = 1'b0;
    if (rst) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (inv_req) begin
            state_nx = S_INVAL;
          end else if (cpu_valid) begin
            cpu_addr_ok = 1'b1;
            state_nx    = S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (hit) begin
            cpu_data_ok = 1'b1;
            if (cpu_valid && !inv_req) begin
              cpu_addr_ok = 1'b1;
              state_nx    = S_LOOKUP;
            end else begin
              state_nx = S_IDLE;
            end
          end else begin
            state_nx = S_MISS;
          end
        end
        S_MISS: begin
          rd_req = 1'b1;
          if (rd_rdy) state_nx = S_REFILL;
        end
        S_REFILL: begin
          if (ret_valid && ret_last) state_nx = S_RESPOND;
        end
        S_RESPOND: begin
          cpu_data_ok = 1'b1;
          cpu_rdata   = crit_word;
          state_nx    = S_IDLE;
        end
        S_INVAL: begin
          if (inv_cnt == IDX_W'(SETS - 1)) begin
            inv_done = 1'b1;
            state_nx = S_IDLE;
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // Request buffer, counters, valid and PLRU state
  always_ff @(posedge clk) begin
    if (rst) begin
      req_addr  <= '0;
      beat_cnt  <= '0;
      inv_cnt   <= '0;
      crit_word <= '0;
      for (int w = 0; w < int'(WAYS); w++) valid_mem[w] <= '0;
      for (int s = 0; s < int'(SETS); s++) plru_mem[s] <= '0;
    end else begin
      if (cpu_addr_ok) req_addr <= cpu_addr;
      if (state == S_MISS) beat_cnt <= '0;
      if (state == S_IDLE) inv_cnt <= '0;
      if (state == S_INVAL) begin
        inv_cnt <= inv_cnt + IDX_W'(1);
        for (int w = 0; w < int'(WAYS); w++) valid_mem[w][inv_cnt] <= 1'b0;
      end
      if ((state == S_LOOKUP) && hit) plru_mem[req_idx] <= plru_upd;
      if ((state == S_REFILL) && ret_valid) begin
        beat_cnt <= beat_cnt + WORD_W'(1);
        if (beat_cnt == req_word) crit_word <= ret_data;
        if (ret_last) begin
          valid_mem[victim][req_idx] <= 1'b1;
          plru_mem[req_idx]          <= plru_upd;
        end
      end
    end
  end

  // Tag and data arrays; contents are qualified by the valid bits
  always_ff @(posedge clk) begin
    if (!rst && (state == S_REFILL) && ret_valid) begin
      data_mem[victim][req_idx][beat_cnt] <= ret_data;
      if (ret_last) tag_mem[victim][req_idx] <= req_tag;
    end
  end

endmodule

// File: tb/tb_icache_nway.sv
// tb_icache_nway: directed checks for icache_nway at default parameters.
module tb_icache_nway;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_valid;
  logic [31:0] cpu_addr;
  logic        cpu_addr_ok;
  logic        cpu_data_ok;
  logic [31:0] cpu_rdata;
  logic        inv_req;
  logic        inv_done;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        rd_rdy;
  logic        ret_valid;
  logic        ret_last;
  logic [31:0] ret_data;

  logic        rst_val;
  int          n_vec = 0;
  int          n_err = 0;

  icache_nway dut (
    .clk(clk), .rst(rst),
    .cpu_valid(cpu_valid), .cpu_addr(cpu_addr), .cpu_addr_ok(cpu_addr_ok),
    .cpu_data_ok(cpu_data_ok), .cpu_rdata(cpu_rdata),
    .inv_req(inv_req), .inv_done(inv_done),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] a;
    logic        rdy;
    logic        rv;
    logic        rl;
    logic [31:0] rd;
    logic        e_aok;
    logic        e_dok;
    logic [31:0] e_rdata;
    logic        e_rreq;
    logic [31:0] e_raddr;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs just after the edge; outputs are checked at negedge
  task automatic drive(input logic v, input logic [31:0] a, input logic inv,
                       input logic rdy, input logic rv, input logic rl,
                       input logic [31:0] rd);
    @(posedge clk);
    #1;
    rst = rst_val; cpu_valid = v; cpu_addr = a; inv_req = inv;
    rd_rdy = rdy; ret_valid = rv; ret_last = rl; ret_data = rd;
    @(negedge clk);
  endtask

  task automatic idle_cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic hit_fetch(input logic [31:0] addr, input logic [31:0] exp);
    drive(1'b1, addr, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("hit_accept", 32'(cpu_addr_ok), 32'd1);
    idle_cycle();
    chk("hit_data_ok", 32'(cpu_data_ok), 32'd1);
    if (cpu_data_ok) chk("hit_rdata", cpu_rdata, exp);
    chk("hit_no_rd_req", 32'(rd_req), 32'd0);
  endtask

  // Full miss: accept, lookup miss, optional bus stall, 4 beats, respond
  task automatic miss_fill(input logic [31:0] addr, input logic [31:0] base,
                           input int stall, input bit glitch);
    logic [31:0] line;
    line = {addr[31:4], 4'h0};
    drive(1'b1, addr, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("miss_accept", 32'(cpu_addr_ok), 32'd1);
    idle_cycle();
    chk("miss_lookup_dok", 32'(cpu_data_ok), 32'd0);
    for (int i = 0; i < stall; i++) begin
      drive(1'b1, 32'hDEAD_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("stall_rd_req", 32'(rd_req), 32'd1);
      chk("stall_rd_addr", rd_addr, line);
      chk("stall_addr_ok", 32'(cpu_addr_ok), 32'd0);
    end
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("miss_rd_req", 32'(rd_req), 32'd1);
    chk("miss_rd_addr", rd_addr, line);
    for (int i = 0; i < 4; i++) begin
      if (glitch && i == 1) begin
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hBAD0_BAD0);
        chk("last_no_valid_dok", 32'(cpu_data_ok), 32'd0);
      end
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'(i == 3), base + 32'(i));
      chk("refill_rd_req", 32'(rd_req), 32'd0);
      chk("refill_dok", 32'(cpu_data_ok), 32'd0);
    end
    idle_cycle();
    chk("respond_dok", 32'(cpu_data_ok), 32'd1);
    if (cpu_data_ok) chk("respond_rdata", cpu_rdata, base + 32'(addr[3:2]));
    idle_cycle();
    chk("respond_one_cycle", 32'(cpu_data_ok), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cycles;
    int aok_seen;
    bit done;

    // Cold miss then back-to-back hits
    tbl[0]  = '{1'b1, 32'h1008, 1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  1'b0, 32'h0};
    tbl[1]  = '{1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  1'b0, 32'h0};
    tbl[2]  = '{1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  1'b1, 32'h1000};
    tbl[3]  = '{1'b0, 32'h0,    1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  1'b1, 32'h1000};
    tbl[4]  = '{1'b0, 32'h0,    1'b0, 1'b1, 1'b0, 32'hA0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0};
    tbl[5]  = '{1'b0, 32'h0,    1'b0, 1'b1, 1'b0, 32'hA1, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0};
    tbl[6]  = '{1'b0, 32'h0,    1'b0, 1'b1, 1'b0, 32'hA2, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0};
    tbl[7]  = '{1'b0, 32'h0,    1'b0, 1'b1, 1'b1, 32'hA3, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0};
    tbl[8]  = '{1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'hA2, 1'b0, 32'h0};
    tbl[9]  = '{1'b1, 32'h1000, 1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  1'b0, 32'h0};
    tbl[10] = '{1'b1, 32'h1004, 1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'hA0, 1'b0, 32'h0};
    tbl[11] = '{1'b1, 32'h100C, 1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'hA1, 1'b0, 32'h0};
    tbl[12] = '{1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'hA3, 1'b0, 32'h0};
    tbl[13] = '{1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  1'b0, 32'h0};

    rst = 1'b1; rst_val = 1'b1;
    cpu_valid = 1'b0; cpu_addr = '0; inv_req = 1'b0; rd_rdy = 1'b0;
    ret_valid = 1'b0; ret_last = 1'b0; ret_data = '0;

    // Reset state: outputs held low even with a request present
    repeat (2) begin
      drive(1'b1, 32'h1008, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0);
      chk("rst_addr_ok", 32'(cpu_addr_ok), 32'd0);
      chk("rst_data_ok", 32'(cpu_data_ok), 32'd0);
      chk("rst_rd_req", 32'(rd_req), 32'd0);
      chk("rst_inv_done", 32'(inv_done), 32'd0);
    end
    rst_val = 1'b0;

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].v, tbl[i].a, 1'b0, tbl[i].rdy, tbl[i].rv, tbl[i].rl, tbl[i].rd);
      chk($sformatf("v%0d_addr_ok", i), 32'(cpu_addr_ok), 32'(tbl[i].e_aok));
      chk($sformatf("v%0d_data_ok", i), 32'(cpu_data_ok), 32'(tbl[i].e_dok));
      chk($sformatf("v%0d_rd_req", i), 32'(rd_req), 32'(tbl[i].e_rreq));
      chk($sformatf("v%0d_inv_done", i), 32'(inv_done), 32'd0);
      if (tbl[i].e_dok) chk($sformatf("v%0d_rdata", i), cpu_rdata, tbl[i].e_rdata);
      if (tbl[i].e_rreq) chk($sformatf("v%0d_rd_addr", i), rd_addr, tbl[i].e_raddr);
    end

    // PLRU: 0x1000 in way0, 0x2000 fills way1, hit 0x1000, 0x3000 evicts 0x2000
    hit_fetch(32'h1000, 32'hA0);
    miss_fill(32'h2000, 32'hB0, 0, 1'b0);
    hit_fetch(32'h1000, 32'hA0);
    miss_fill(32'h3004, 32'hC0, 0, 1'b0);
    hit_fetch(32'h1000, 32'hA0);
    hit_fetch(32'h3008, 32'hC2);
    miss_fill(32'h2000, 32'hB0, 0, 1'b0);

    // Stalled bus plus a ret_last without ret_valid mid-fill
    miss_fill(32'h5048, 32'hE0, 10, 1'b1);
    hit_fetch(32'h5044, 32'hE1);

    // Invalidate wins over a simultaneous fetch
    drive(1'b1, 32'h1000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("inv_prio_addr_ok", 32'(cpu_addr_ok), 32'd0);
    cycles = 0; aok_seen = 0; done = 1'b0;
    while (!done && cycles < 400) begin
      drive(1'b1, 32'h1000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      cycles++;
      if (cpu_addr_ok) aok_seen++;
      if (inv_done) done = 1'b1;
    end
    chk("inv_done_seen", 32'(done), 32'd1);
    chk("inv_cycles", 32'(cycles), 32'd256);
    chk("inv_addr_ok_low", 32'(aok_seen), 32'd0);

    // Refetch 0x1000 misses; reset after two beats abandons the fill
    drive(1'b1, 32'h1000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("post_inv_accept", 32'(cpu_addr_ok), 32'd1);
    idle_cycle();
    chk("post_inv_miss", 32'(cpu_data_ok), 32'd0);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("post_inv_rd_req", 32'(rd_req), 32'd1);
    chk("post_inv_rd_addr", rd_addr, 32'h1000);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hF0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hF1);
    rst_val = 1'b1;
    drive(1'b1, 32'h1000, 1'b0, 1'b1, 1'b1, 1'b0, 32'hF2);
    chk("midrst_addr_ok", 32'(cpu_addr_ok), 32'd0);
    chk("midrst_data_ok", 32'(cpu_data_ok), 32'd0);
    chk("midrst_rd_req", 32'(rd_req), 32'd0);
    chk("midrst_inv_done", 32'(inv_done), 32'd0);
    rst_val = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hF3);
    chk("late_beat_dok", 32'(cpu_data_ok), 32'd0);
    chk("late_beat_rd_req", 32'(rd_req), 32'd0);
    idle_cycle();
    chk("late_beat_no_respond", 32'(cpu_data_ok), 32'd0);
    miss_fill(32'h1004, 32'h50, 0, 1'b0);
    hit_fetch(32'h100C, 32'h53);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
